// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// the supported operand-width range.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder built from two half adders; the single arithmetic
// cell that the serial controller reuses for every bit position.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Combinational half adder, building block of the serial adder's full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one fa_cell stepped LSB-first over WIDTH cycles,
// with a start/busy/done handshake and registered result outputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; outputs hold the last result
// ST_RUN  | one operand bit pair added per clock, LSB first
// ST_DONE | result just published (done high); start here chains next op
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    import serial_adder_ctrl_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH out of supported range");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] shreg_a;
    logic [WIDTH-1:0] shreg_b;
    logic [WIDTH-1:0] shreg_s;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] s_next;
    logic             last_bit;

    fa_cell u_fa (
        .a    (shreg_a[0]),
        .b    (shreg_b[0]),
        .cin  (carry),
        .s    (s_bit),
        .cout (c_bit)
    );

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_snext_one
            assign s_next = s_bit;
        end else begin : g_snext_multi
            assign s_next = {s_bit, shreg_s[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg_a   <= '0;
            shreg_b   <= '0;
            shreg_s   <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        shreg_a <= a;
                        shreg_b <= b;
                        carry   <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    shreg_a <= shreg_a >> 1;
                    shreg_b <= shreg_b >> 1;
                    shreg_s <= s_next;
                    carry   <= c_bit;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        sum       <= s_next;
                        carry_out <= c_bit;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1) with an expected-result queue.
module tb_serial_adder_ctrl;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       carry_out1;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .carry_out (carry_out1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, output int t0);
        logic [8:0] full;
        exp_t       e;
        full   = {1'b0, av} + {1'b0, bv};
        e.sum  = full[7:0];
        e.cout = full[8];
        sb.push_back(e);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(input string tag, input int t0, input bit chk_pulse, output int tdone);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tdone = cyc;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc - t0), 32'd8);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(e.sum));
            check({tag, "_carry_out"}, 32'(carry_out), 32'(e.cout));
        end
        if (chk_pulse) begin
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int t0;
        int t0b;
        int td;
        int td1;
        int td2;
        int ndone;

        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(carry_out), 32'd0);
        check("rst_w1_sum", 32'(sum1), 32'd0);
        check("rst_w1_cout", 32'(carry_out1), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add
        start_op(8'h3C, 8'h45, t0);
        check("basic_busy_after_start", 32'(busy), 32'd1);
        check("basic_no_early_done", 32'(done), 32'd0);
        wait_done("basic", t0, 1'b1, td);

        // Overflow cases
        start_op(8'hFF, 8'h01, t0);
        wait_done("ovf1", t0, 1'b1, td);
        start_op(8'hFF, 8'hFF, t0);
        wait_done("ovf2", t0, 1'b1, td);

        // start during RUN must be ignored
        start_op(8'h10, 8'h20, t0);
        repeat (2) @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", t0, 1'b1, td);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("ignore_no_second_done", 32'(ndone), 32'd0);
        check("ignore_sum_held", 32'(sum), 32'h30);

        // Reset mid-operation
        start_op(8'h7F, 8'h01, t0);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(carry_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        check("midrst_idle_done", 32'(done), 32'd0);
        start_op(8'h02, 8'h03, t0);
        wait_done("after_rst", t0, 1'b1, td);

        // Back-to-back: second start presented during the DONE cycle
        start_op(8'h01, 8'h01, t0);
        wait_done("b2b1", t0, 1'b0, td1);
        start_op(8'h80, 8'h80, t0b);
        check("b2b_accept_busy", 32'(busy), 32'd1);
        check("b2b_done_dropped", 32'(done), 32'd0);
        wait_done("b2b2", t0b, 1'b1, td2);
        check("b2b_done_spacing", 32'(td2 - td1), 32'd9);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // WIDTH=1 instance
        a1     = 1'b1;
        b1     = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("w1_busy", 32'(busy1), 32'd1);
        check("w1_no_early_done", 32'(done1), 32'd0);
        @(negedge clk);
        check("w1_done", 32'(done1), 32'd1);
        check("w1_sum", 32'(sum1), 32'd0);
        check("w1_cout", 32'(carry_out1), 32'd1);
        check("w1_busy_low", 32'(busy1), 32'd0);
        @(negedge clk);
        a1     = 1'b0;
        b1     = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        check("w1b_done", 32'(done1), 32'd1);
        check("w1b_sum", 32'(sum1), 32'd1);
        check("w1b_cout", 32'(carry_out1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
